// File: rtl/seq_frame_ctrl_pkg.sv
// Shared definitions for the bit-serial frame controller: FSM state
// encoding, default pattern settings and a width helper for index counters.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam int         DEF_DATA_W  = 8;
  localparam int         DEF_CNT_W   = 8;
  localparam int         DEF_PAT_LEN = 4;
  localparam logic [3:0] DEF_PAT     = 4'b1101;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_frame_ctrl_match_core.sv
// Overlapping serial pattern detector: history shift register, fill counter
// and comparator. The match output reflects the state after the bit being
// presented this cycle has been absorbed.
module seq_match_core
  import seq_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PAT     = PAT_LEN'(DEF_PAT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic bit_en,
  input  logic bit_in,
  output logic match
);

  localparam int FILL_W = idx_w(PAT_LEN + 1);

  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;

  // Next history/fill: new bit enters at the LSB, fill saturates at PAT_LEN.
  assign hist_d = (hist_q << 1) | PAT_LEN'(bit_in);
  assign fill_d = (fill_q == FILL_W'(PAT_LEN)) ? fill_q : fill_q + FILL_W'(1);

  // The fill guard keeps a zero-initialised history from matching PAT=0...0.
  assign match = bit_en && (fill_d == FILL_W'(PAT_LEN)) && (hist_d == PAT);

  // History and fill registers; clr wipes them between frames.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clr) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (bit_en) begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_frame_ctrl.sv
// Frame controller: accepts words over valid/ready, serialises them MSB
// first into the match core, counts matches across a frame and hands the
// count back over a result handshake.
module seq_frame_ctrl
  import seq_pkg::*;
#(
  parameter int                 DATA_W  = DEF_DATA_W,
  parameter int                 CNT_W   = DEF_CNT_W,
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PAT     = PAT_LEN'(DEF_PAT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              res_valid,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_sat,
  input  logic              res_ready,
  output logic              busy
);

  if ((PAT_LEN < 1) || (PAT_LEN > DATA_W)) begin : g_bad_pat_len
    $error("seq_frame_ctrl: PAT_LEN must be in 1..DATA_W");
  end

  localparam int               IDX_W   = idx_w(DATA_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic               last_q, last_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;

  logic shift_en;
  logic core_clr;
  logic match;
  logic end_of_word;

  // Clear wins over everything, so it also suppresses the bit going in.
  assign shift_en    = (state_q == SHIFT) && !clear;
  assign core_clr    = clear || ((state_q == RESULT) && res_ready);
  assign end_of_word = (bit_idx_q == IDX_W'(DATA_W - 1));

  seq_match_core #(
    .PAT_LEN (PAT_LEN),
    .PAT     (PAT)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .clr    (core_clr),
    .bit_en (shift_en),
    .bit_in (shreg_q[DATA_W-1]),
    .match  (match)
  );

  // FSM, word shifter and saturating match counter next-state logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    shreg_d   = shreg_q;
    last_d    = last_q;
    bit_idx_d = bit_idx_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;

    if (clear) begin
      state_d   = IDLE;
      shreg_d   = '0;
      last_d    = 1'b0;
      bit_idx_d = '0;
      cnt_d     = '0;
      sat_d     = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            shreg_d   = in_data;
            last_d    = in_last;
            bit_idx_d = '0;
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          shreg_d   = shreg_q << 1;
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (match) begin
            if (cnt_q == CNT_MAX) sat_d = 1'b1;
            else                  cnt_d = cnt_q + CNT_W'(1);
          end
          if (end_of_word) begin
            bit_idx_d = '0;
            state_d   = last_q ? RESULT : IDLE;
          end
        end
        RESULT: begin
          if (res_ready) begin
            state_d = IDLE;
            cnt_d   = '0;
            sat_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      last_q    <= 1'b0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      last_q    <= last_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign res_valid = (state_q == RESULT);
  assign busy      = (state_q != IDLE);
  assign res_count = cnt_q;
  assign res_sat   = sat_q;

endmodule

// File: tb/tb_seq_frame_ctrl.sv
// Bench for seq_frame_ctrl: two instances (8-bit and 2-bit counters) share
// one stimulus stream; a bit-queue reference model counts pattern hits.
module tb_seq_frame_ctrl;

  localparam int         DATA_W  = 8;
  localparam int         PAT_LEN = 4;
  localparam logic [3:0] PAT     = 4'b1101;

  logic             clk = 1'b0;
  logic             rst, clear, in_valid, in_last, res_ready;
  logic [DATA_W-1:0] in_data;

  logic       in_ready, res_valid, res_sat, busy;
  logic [7:0] res_count;
  logic       in_ready2, res_valid2, res_sat2, busy2;
  logic [1:0] res_count2;

  int n_cmp  = 0;
  int n_fail = 0;
  bit frame_q[$];

  always #5 clk = ~clk;

  seq_frame_ctrl #(.DATA_W(DATA_W), .CNT_W(8), .PAT_LEN(PAT_LEN), .PAT(PAT)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .res_valid(res_valid),
    .res_count(res_count), .res_sat(res_sat), .res_ready(res_ready), .busy(busy)
  );

  seq_frame_ctrl #(.DATA_W(DATA_W), .CNT_W(2), .PAT_LEN(PAT_LEN), .PAT(PAT)) u_dut2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready2), .res_valid(res_valid2),
    .res_count(res_count2), .res_sat(res_sat2), .res_ready(res_ready), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: count every window of PAT_LEN consecutive frame bits equal to PAT.
  function automatic int model_count();
    int n = 0;
    for (int i = PAT_LEN - 1; i < frame_q.size(); i++) begin
      bit hit = 1'b1;
      for (int k = 0; k < PAT_LEN; k++)
        if (frame_q[i - k] != PAT[k]) hit = 1'b0;
      if (hit) n++;
    end
    return n;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic load_bits(input logic [DATA_W-1:0] w);
    for (int b = DATA_W - 1; b >= 0; b--) frame_q.push_back(w[b]);
  endtask

  // Offer one word, let it serialise, and check the end-of-word state.
  task automatic push_word(input logic [DATA_W-1:0] w, input logic last, output int waited);
    waited = 0;
    while (!in_ready && waited < 40) begin
      tick();
      waited++;
    end
    check("accept_timeout", 32'(waited < 40), 32'd1);
    in_valid = 1'b1; in_data = w; in_last = last;
    tick();
    in_valid = 1'b0; in_data = $urandom; in_last = $urandom;
    load_bits(w);
    check("shift_in_ready", in_ready, 1'b0);
    check("shift_busy", busy, 1'b1);
    repeat (DATA_W - 1) tick();
    check("early_res_valid", res_valid, 1'b0);
    tick();
    if (last) check("word_end_res_valid", res_valid, 1'b1);
    else      check("word_end_in_ready", in_ready, 1'b1);
  endtask

  task automatic check_result(input string tag);
    int n = model_count();
    check({tag, "_valid"},  res_valid,  1'b1);
    check({tag, "_count"},  res_count,  32'(min_i(n, 255)));
    check({tag, "_sat"},    res_sat,    32'(n > 255));
    check({tag, "_valid2"}, res_valid2, 1'b1);
    check({tag, "_count2"}, res_count2, 32'(min_i(n, 3)));
    check({tag, "_sat2"},   res_sat2,   32'(n > 3));
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    frame_q.delete();
    check("post_res_valid", res_valid, 1'b0);
    check("post_in_ready", in_ready, 1'b1);
    check("post_count", res_count, 32'd0);
    check("post_sat2", res_sat2, 1'b0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int w;
    logic [7:0] held;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; res_ready = 1'b0;
    #3;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_count", res_count, 32'd0);
    check("rst_sat", res_sat, 1'b0);
    check("rst_busy", busy, 1'b0);
    #12 rst = 1'b0;
    tick();

    // Single word with two overlapping hits.
    push_word(8'b1101_1010, 1'b1, w);
    check_result("single");
    take_result();

    // Match spanning a word boundary; second word accepted without stalling.
    push_word(8'b0000_0110, 1'b0, w);
    push_word(8'b1000_0000, 1'b1, w);
    check("cross_accept_wait", w, 32'd0);
    check_result("cross");
    take_result();

    // Three words: 6 hits, saturates the 2-bit instance.
    push_word(8'b1101_1010, 1'b0, w);
    push_word(8'b1101_1010, 1'b0, w);
    push_word(8'b1101_1010, 1'b1, w);
    check_result("sat");

    // Backpressure: result must hold; a pending word must not be taken.
    held = res_count;
    in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_res_valid", res_valid, 1'b1);
      check("bp_count", res_count, 32'(held));
      check("bp_in_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    check("bp_count_value", res_count, 32'd6);
    take_result();

    // Clear during the 4th shift cycle.
    in_valid = 1'b1; in_data = 8'b1101_1010; in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_in_ready", in_ready, 1'b1);
    check("clr_busy", busy, 1'b0);
    check("clr_count", res_count, 32'd0);
    frame_q.delete();
    push_word(8'b0000_1101, 1'b1, w);
    check_result("after_clear");
    take_result();

    // Asynchronous reset mid-word, observed before any clock edge.
    in_valid = 1'b1; in_data = 8'b1101_1101; in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_count", res_count, 32'd0);
    #1 rst = 1'b0;
    tick();
    push_word(8'b1101_1010, 1'b1, w);
    check_result("after_rst");
    take_result();

    // Random frames against the bit-queue model.
    for (int f = 0; f < 24; f++) begin
      int nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) begin
        logic [7:0] d = (($urandom_range(0, 2) == 0) ? 8'b1101_1010 : 8'($urandom));
        push_word(d, 1'(k == nw - 1), w);
      end
      check_result("rand");
      repeat ($urandom_range(0, 3)) tick();
      take_result();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
